// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with flush, optional skid entry
// and saturating stall counter.
module pipe_stage_reg #(
    parameter int               WIDTH  = 96,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'({32'h00000013, 64'h0}),
    parameter bit               SKID   = 1'b1,
    parameter int               CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_stall_cnt
);
    logic             main_valid, main_valid_d;
    logic [WIDTH-1:0] main_data, main_data_d;
    logic             skid_valid, skid_valid_d;
    logic [WIDTH-1:0] skid_data, skid_data_d;
    logic             in_xfer, out_xfer;

    // With a skid entry, ready depends only on the skid flop, never on i_ready.
    assign o_ready  = SKID ? ~skid_valid : (~main_valid | i_ready);
    assign in_xfer  = i_valid & o_ready;
    assign out_xfer = main_valid & i_ready;
    assign o_valid  = main_valid;
    assign o_data   = main_data;

    always_comb begin
        main_valid_d = main_valid;
        main_data_d  = main_data;
        skid_valid_d = skid_valid;
        skid_data_d  = skid_data;
        if (i_flush) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE;
        end else if (SKID && main_valid && !out_xfer) begin
            if (in_xfer) begin
                skid_valid_d = 1'b1;
                skid_data_d  = i_data;
            end
        end else if (SKID && skid_valid) begin
            main_data_d  = skid_data;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE;
        end else if (in_xfer) begin
            main_valid_d = 1'b1;
            main_data_d  = i_data;
        end else if (out_xfer) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            main_valid  <= 1'b0;
            main_data   <= BUBBLE;
            skid_valid  <= 1'b0;
            skid_data   <= BUBBLE;
            o_stall_cnt <= '0;
        end else begin
            main_valid <= main_valid_d;
            main_data  <= main_data_d;
            skid_valid <= skid_valid_d;
            skid_data  <= skid_data_d;
            if (main_valid && !i_ready && !(&o_stall_cnt))
                o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg (skid, saturating
// counter and combinational-ready variants).
module tb_pipe_stage_reg;
    localparam logic [95:0] BUB = {32'h00000013, 64'h0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vin = 1'b0, rdy = 1'b0, flush = 1'b0;
    logic [95:0] din = '0;
    logic        oready, ovalid;
    logic [95:0] odata;
    logic [15:0] cnt;

    logic        sat_ready, sat_valid;
    logic [95:0] sat_data;
    logic [3:0]  sat_cnt;

    logic        v0 = 1'b0, r0 = 1'b0, f0 = 1'b0;
    logic [95:0] d0 = '0;
    logic        oready0, ovalid0;
    logic [95:0] odata0;
    logic [15:0] cnt0;

    int checks = 0;
    int failures = 0;
    logic [95:0] q[$];
    int exp_cnt = 0;

    always #5 clk = ~clk;

    pipe_stage_reg u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin), .o_ready(oready), .i_data(din),
        .o_valid(ovalid), .i_ready(rdy), .o_data(odata), .i_flush(flush), .o_stall_cnt(cnt)
    );

    pipe_stage_reg #(.CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin), .o_ready(sat_ready), .i_data(din),
        .o_valid(sat_valid), .i_ready(rdy), .o_data(sat_data), .i_flush(flush), .o_stall_cnt(sat_cnt)
    );

    pipe_stage_reg #(.SKID(1'b0)) u_s0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(oready0), .i_data(d0),
        .o_valid(ovalid0), .i_ready(r0), .o_data(odata0), .i_flush(f0), .o_stall_cnt(cnt0)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [95:0] pl(input logic [31:0] insn, input logic [31:0] pc);
        return {insn, pc, pc + 32'd4};
    endfunction

    // Sample mid-cycle, score this cycle's transfers, then advance one edge.
    task automatic tick();
        #3;
        if (ovalid && rdy) begin
            if (q.size() == 0) chk("sb_unexpected_valid", ovalid, 1'b0);
            else chk("sb_data", odata, q.pop_front());
        end
        if (flush) q.delete();
        else if (vin && oready) q.push_back(din);
        if (ovalid && !rdy && exp_cnt < 65535) exp_cnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", ovalid, 1'b0);
        chk("rst_data", odata, BUB);
        chk("rst_ready", oready, 1'b1);
        chk("rst_cnt", cnt, 16'd0);
        rst_n = 1'b1;
        tick();

        // 2: streaming at full rate
        rdy = 1'b1; vin = 1'b1; din = pl(32'h00500093, 32'h0);
        tick();
        chk("s2_valid", ovalid, 1'b1);
        chk("s2_ready", oready, 1'b1);
        din = pl(32'h00100113, 32'h4);
        tick();
        chk("s2_ready2", oready, 1'b1);
        vin = 1'b0;
        tick();
        chk("s2_empty", ovalid, 1'b0);

        // 3: backpressure fills main then skid
        rdy = 1'b0; vin = 1'b1; din = pl(32'h000000a1, 32'h100);
        tick();
        din = pl(32'h000000b2, 32'h104);
        tick();
        chk("s3_ready_low", oready, 1'b0);
        chk("s3_hold_a", odata, pl(32'h000000a1, 32'h100));
        vin = 1'b0;
        tick();
        tick();
        rdy = 1'b1;
        tick();
        chk("s3_ready_back", oready, 1'b1);
        chk("s3_b_main", odata, pl(32'h000000b2, 32'h104));
        tick();
        chk("s3_drained", ovalid, 1'b0);
        chk("s3_cnt", cnt, 16'd3);

        // 4: flush with main, skid and a new input all pending
        rdy = 1'b0; vin = 1'b1; din = pl(32'h000000a3, 32'h200);
        tick();
        din = pl(32'h000000b4, 32'h204);
        tick();
        din = pl(32'h000000c5, 32'h208); flush = 1'b1;
        tick();
        chk("s4_valid", ovalid, 1'b0);
        chk("s4_data", odata, BUB);
        chk("s4_ready", oready, 1'b1);
        chk("s4_cnt_kept", cnt, 16'd5);
        flush = 1'b0; vin = 1'b0; rdy = 1'b1;
        repeat (3) tick();
        chk("s4_none_out", ovalid, 1'b0);
        chk("s4_cnt_model", cnt, 16'(exp_cnt));

        // mid-operation asynchronous reset
        rdy = 1'b0; vin = 1'b1; din = pl(32'h000000d6, 32'h300);
        tick();
        din = pl(32'h000000e7, 32'h304);
        tick();
        vin = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", ovalid, 1'b0);
        chk("mr_data", odata, BUB);
        chk("mr_ready", oready, 1'b1);
        chk("mr_cnt", cnt, 16'd0);
        q.delete();
        exp_cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 5: saturation of the 4-bit counter
        vin = 1'b1; din = pl(32'h000000f8, 32'h400);
        tick();
        vin = 1'b0;
        repeat (10) tick();
        chk("s5_sat_mid", sat_cnt, 4'd10);
        repeat (10) tick();
        chk("s5_sat_cap", sat_cnt, 4'd15);
        chk("s5_wide_cnt", cnt, 16'd20);
        chk("s5_cnt_model", cnt, 16'(exp_cnt));
        rdy = 1'b1;
        tick();
        chk("s5_sat_hold", sat_cnt, 4'd15);

        // 6: single register with combinational ready
        r0 = 1'b1; v0 = 1'b1; d0 = pl(32'h00000111, 32'h500);
        tick();
        chk("s6_ready_comb", oready0, 1'b1);
        chk("s6_first", odata0, pl(32'h00000111, 32'h500));
        d0 = pl(32'h00000222, 32'h504);
        tick();
        chk("s6_replace", odata0, pl(32'h00000222, 32'h504));
        r0 = 1'b0;
        #1 chk("s6_ready_low", oready0, 1'b0);
        d0 = pl(32'h00000333, 32'h508);
        tick();
        chk("s6_held", odata0, pl(32'h00000222, 32'h504));
        r0 = 1'b1; v0 = 1'b0;
        #1 chk("s6_ready_high", oready0, 1'b1);
        tick();
        chk("s6_empty_valid", ovalid0, 1'b0);
        chk("s6_empty_data", odata0, BUB);

        chk("sb_leftover", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
